// File: rtl/iter_shift_unit.sv
// iter_shift_unit: iterative SLL/SRL/SRA engine that shifts at most STEP bits per clock, with a START/BUSY/DONE handshake.
// Define SHIFT_ROTATE_EN to build rotate-right for OP=11; without it, OP=11 behaves as SRL.
module iter_shift_unit #(
    parameter int N    = 32,
    parameter int STEP = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [1:0]           OP,
    input  logic [N-1:0]         DATA_IN,
    input  logic [$clog2(N)-1:0] SHIFT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [N-1:0]         DATA_OUT
);
    localparam int SW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SW:0] STEP_C = (SW+1)'(STEP);

    logic [1:0]    state_reg, state_next;
    logic [N-1:0]  work_reg, work_next;
    logic [SW-1:0] rem_reg, rem_next;
    logic [1:0]    op_reg, op_next;
    logic [N-1:0]  out_reg, out_next;

    logic          rem_small;
    logic [SW:0]   k_wide;
    logic [SW-1:0] rem_run;
    logic [STEP:0][N-1:0] cand;
    logic [N-1:0]  step_val;

    // Step size k = min(REM, STEP); once REM fits in one step the op finishes this cycle.
    assign rem_small = ({1'b0, rem_reg} <= STEP_C);
    assign k_wide    = rem_small ? {1'b0, rem_reg} : STEP_C;
    assign rem_run   = rem_small ? '0 : (rem_reg - SW'(STEP));

    // One candidate per possible step distance 0..STEP; k picks among them.
    for (genvar gi = 0; gi <= STEP; gi++) begin : g_step
        logic [N-1:0] sll_v;
        logic [N-1:0] srl_v;
        logic [N-1:0] sra_v;

        assign sll_v = work_reg << gi;
        assign srl_v = work_reg >> gi;
        // Sign fill is built explicitly so the result never depends on expression signedness.
        assign sra_v = srl_v | ({N{work_reg[N-1]}} << (N - gi));

`ifdef SHIFT_ROTATE_EN
        logic [N-1:0] ror_v;
        assign ror_v = srl_v | (work_reg << (N - gi));
        assign cand[gi] = (op_reg == 2'b00) ? sll_v :
                          (op_reg == 2'b10) ? sra_v :
                          (op_reg == 2'b11) ? ror_v : srl_v;
`else
        assign cand[gi] = (op_reg == 2'b00) ? sll_v :
                          (op_reg == 2'b10) ? sra_v : srl_v;
`endif
    end

    always_comb begin
        step_val = cand[0];
        for (int i = 1; i <= STEP; i++) begin
            if (k_wide == (SW+1)'(i)) begin
                step_val = cand[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        rem_next   = rem_reg;
        op_next    = op_reg;
        out_next   = out_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (START) begin
                    work_next = DATA_IN;
                    rem_next  = SHIFT;
                    op_next   = OP;
                    if (SHIFT == '0) begin
                        state_next = S_DONE;
                        out_next   = DATA_IN;
                    end else begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                work_next = step_val;
                rem_next  = rem_run;
                if (rem_run == '0) begin
                    state_next = S_DONE;
                    out_next   = step_val;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= S_IDLE;
            work_reg  <= '0;
            rem_reg   <= '0;
            op_reg    <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            rem_reg   <= rem_next;
            op_reg    <= op_next;
            out_reg   <= out_next;
        end
    end

    assign BUSY     = (state_reg == S_RUN);
    assign DONE     = (state_reg == S_DONE);
    assign DATA_OUT = out_reg;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit (N=32, STEP=4): expected results are queued at stimulus time and popped at DONE.
module tb_iter_shift_unit;
    localparam int N    = 32;
    localparam int STEP = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [1:0]  OP;
    logic [31:0] DATA_IN;
    logic [4:0]  SHIFT;
    logic        BUSY;
    logic        DONE;
    logic [31:0] DATA_OUT;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    iter_shift_unit #(.N(N), .STEP(STEP)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .OP       (OP),
        .DATA_IN  (DATA_IN),
        .SHIFT    (SHIFT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DATA_OUT (DATA_OUT)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] fill;
        fill = {32{d[31]}};
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return (d >> s) | ~(32'hFFFF_FFFF >> s) & fill;
`ifdef SHIFT_ROTATE_EN
            default: return (d >> s) | (d << (6'd32 - {1'b0, s}));
`else
            default: return d >> s;
`endif
        endcase
    endfunction

    function automatic int lat(input logic [4:0] s);
        return (int'(s) + STEP - 1) / STEP;
    endfunction

    // Drives one operation and waits (bounded) for DONE; done_cyc = -1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                          output int done_cyc, output int busy_cyc, output logic [31:0] res);
        @(negedge CLK);
        START = 1'b1; OP = op; DATA_IN = d; SHIFT = s;
        @(negedge CLK);
        START = 1'b0; OP = 2'($urandom); DATA_IN = $urandom; SHIFT = 5'($urandom);
        done_cyc = -1;
        busy_cyc = 0;
        res = 'x;
        for (int c = 1; c <= 40; c++) begin
            if (BUSY) busy_cyc++;
            if (DONE) begin
                done_cyc = c;
                res = DATA_OUT;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 1'b0; OP = '0; DATA_IN = '0; SHIFT = '0;
        repeat (3) @(negedge CLK);
        checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else passed++;
        checks++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else passed++;
        checks++; if (DATA_OUT !== 32'h0) $display("FAIL reset_data: got %h want 00000000", DATA_OUT); else passed++;
        RST_N = 1'b1;
        $display("reset: busy=%b done=%b data_out=%h", BUSY, DONE, DATA_OUT);
    endtask

    task automatic test_sra();
        int dc, bc;
        logic [31:0] r, e;
        exp_q.push_back(32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 5'd31, dc, bc, r);
        e = exp_q.pop_front();
        checks++; if (r !== e) $display("FAIL sra31_data: got %h want %h", r, e); else passed++;
        checks++; if (dc !== 9) $display("FAIL sra31_done_cycle: got %0d want 9", dc); else passed++;
        checks++; if (bc !== 8) $display("FAIL sra31_busy_cycles: got %0d want 8", bc); else passed++;
        $display("sra 80000000>>>31 -> %h done@%0d busy=%0d", r, dc, bc);
    endtask

    task automatic test_srl_sll();
        int dc, bc;
        logic [31:0] r, e;
        exp_q.push_back(32'h0780_0000);
        run_op(2'b01, 32'hF000_000F, 5'd5, dc, bc, r);
        e = exp_q.pop_front();
        checks++; if (r !== e) $display("FAIL srl5_data: got %h want %h", r, e); else passed++;
        checks++; if (dc !== 3) $display("FAIL srl5_done_cycle: got %0d want 3", dc); else passed++;
        checks++; if (bc !== 2) $display("FAIL srl5_busy_cycles: got %0d want 2", bc); else passed++;
        $display("srl f000000f>>5 -> %h done@%0d", r, dc);
        exp_q.push_back(32'h0000_01E0);
        run_op(2'b00, 32'hF000_000F, 5'd5, dc, bc, r);
        e = exp_q.pop_front();
        checks++; if (r !== e) $display("FAIL sll5_data: got %h want %h", r, e); else passed++;
        checks++; if (dc !== 3) $display("FAIL sll5_done_cycle: got %0d want 3", dc); else passed++;
        checks++; if (bc !== 2) $display("FAIL sll5_busy_cycles: got %0d want 2", bc); else passed++;
        $display("sll f000000f<<5 -> %h done@%0d", r, dc);
    endtask

    task automatic test_zero_shift();
        int dc, bc;
        logic [31:0] r, e;
        for (int op = 0; op < 4; op++) begin
            exp_q.push_back(32'h1234_5678);
            run_op(2'(op), 32'h1234_5678, 5'd0, dc, bc, r);
            e = exp_q.pop_front();
            checks++; if (r !== e) $display("FAIL zero_op%0d_data: got %h want %h", op, r, e); else passed++;
            checks++; if (dc !== 1) $display("FAIL zero_op%0d_done_cycle: got %0d want 1", op, dc); else passed++;
            checks++; if (bc !== 0) $display("FAIL zero_op%0d_busy_cycles: got %0d want 0", op, bc); else passed++;
            $display("op%0d shift0 -> %h done@%0d busy=%0d", op, r, dc, bc);
        end
    endtask

    task automatic test_op11();
        int dc, bc;
        logic [31:0] r, e;
`ifdef SHIFT_ROTATE_EN
        exp_q.push_back(32'h8000_0000);
`else
        exp_q.push_back(32'h0000_0000);
`endif
        run_op(2'b11, 32'h0000_0001, 5'd1, dc, bc, r);
        e = exp_q.pop_front();
        checks++; if (r !== e) $display("FAIL op11_data: got %h want %h", r, e); else passed++;
        checks++; if (dc !== 2) $display("FAIL op11_done_cycle: got %0d want 2", dc); else passed++;
        $display("op11 00000001 by 1 -> %h done@%0d", r, dc);
    endtask

    task automatic test_start_during_run();
        int dc;
        logic [31:0] r, e;
        exp_q.push_back(32'h000F_F000);
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; DATA_IN = 32'h0000_00FF; SHIFT = 5'd12;
        dc = -1;
        r = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (c == 1) begin OP = 2'b01; DATA_IN = 32'hFFFF_FFFF; SHIFT = 5'd1; end
            if (c == 3) START = 1'b0;
            if (DONE) begin dc = c; r = DATA_OUT; break; end
        end
        e = exp_q.pop_front();
        checks++; if (r !== e) $display("FAIL start_in_run_data: got %h want %h", r, e); else passed++;
        checks++; if (dc !== 4) $display("FAIL start_in_run_done_cycle: got %0d want 4", dc); else passed++;
        @(negedge CLK);
        checks++; if (DATA_OUT !== e) $display("FAIL start_in_run_hold: got %h want %h", DATA_OUT, e); else passed++;
        $display("sll 000000ff<<12 with start in run -> %h done@%0d", r, dc);
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [31:0] r1, r2, e;
        logic b4;
        exp_q.push_back(32'h0780_0000);
        exp_q.push_back(32'h0000_01E0);
        @(negedge CLK);
        START = 1'b1; OP = 2'b01; DATA_IN = 32'hF000_000F; SHIFT = 5'd5;
        first = -1; second = -1; r1 = 'x; r2 = 'x; b4 = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (c == 1) OP = 2'b00;
            if (c == 4) begin START = 1'b0; b4 = BUSY; end
            if (DONE && first < 0) begin
                first = c; r1 = DATA_OUT;
            end else if (DONE && second < 0) begin
                second = c; r2 = DATA_OUT; break;
            end
        end
        e = exp_q.pop_front();
        checks++; if (r1 !== e) $display("FAIL b2b_first_data: got %h want %h", r1, e); else passed++;
        checks++; if (first !== 3) $display("FAIL b2b_first_done: got %0d want 3", first); else passed++;
        e = exp_q.pop_front();
        checks++; if (r2 !== e) $display("FAIL b2b_second_data: got %h want %h", r2, e); else passed++;
        checks++; if (second !== 6) $display("FAIL b2b_second_done: got %0d want 6", second); else passed++;
        checks++; if (b4 !== 1'b1) $display("FAIL b2b_no_idle_busy: got %b want 1", b4); else passed++;
        $display("back-to-back: %h done@%0d, %h done@%0d", r1, first, r2, second);
    endtask

    task automatic test_reset_during_run();
        int dc, bc;
        logic saw;
        logic [31:0] r, e;
        @(negedge CLK);
        START = 1'b1; OP = 2'b10; DATA_IN = 32'h8000_0000; SHIFT = 5'd20;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", BUSY); else passed++;
        checks++; if (DONE !== 1'b0) $display("FAIL abort_done: got %b want 0", DONE); else passed++;
        checks++; if (DATA_OUT !== 32'h0) $display("FAIL abort_data: got %h want 00000000", DATA_OUT); else passed++;
        RST_N = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) $display("FAIL abort_no_done: got %b want 0", saw); else passed++;
        exp_q.push_back(32'h0000_01E0);
        run_op(2'b00, 32'hF000_000F, 5'd5, dc, bc, r);
        e = exp_q.pop_front();
        checks++; if (r !== e) $display("FAIL after_abort_data: got %h want %h", r, e); else passed++;
        checks++; if (dc !== 3) $display("FAIL after_abort_done: got %0d want 3", dc); else passed++;
        $display("reset during run: aborted, next op -> %h done@%0d", r, dc);
    endtask

    task automatic test_random();
        int dc, bc;
        logic [31:0] r, e, d;
        logic [1:0] op;
        logic [4:0] s;
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            s  = 5'($urandom_range(0, 31));
            exp_q.push_back(model(op, d, s));
            run_op(op, d, s, dc, bc, r);
            e = exp_q.pop_front();
            checks++; if (r !== e) $display("FAIL rand%0d_data: op=%0d d=%h s=%0d got %h want %h", i, op, d, s, r, e); else passed++;
            checks++; if (dc !== lat(s) + 1) $display("FAIL rand%0d_done_cycle: got %0d want %0d", i, dc, lat(s) + 1); else passed++;
            $display("rand%0d op=%0d d=%h s=%0d -> %h done@%0d", i, op, d, s, r, dc);
        end
    endtask

    initial begin
        test_reset();
        test_sra();
        test_srl_sll();
        test_zero_shift();
        test_op11();
        test_start_during_run();
        test_back_to_back();
        test_reset_during_run();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
